// File: rtl/lcd_pkg.sv
// Shared constants for the LCD character path: command codes, ASCII codes,
// writer FSM encoding and the digit picker for the HH:MM:SS layout.
package lcd_pkg;

  localparam logic [7:0] LCD_CMD_SET_DDRAM = 8'h80;
  localparam logic [7:0] ASCII_ZERO        = 8'h30;
  localparam logic [7:0] ASCII_SPACE       = 8'h20;
  localparam logic [7:0] ASCII_QMARK       = 8'h3F;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ADDR  = 2'd1;
  localparam logic [1:0] ST_CHARS = 2'd2;

  localparam logic [2:0] LAST_CHAR_IDX = 3'd7;

  // Character slots 2 and 5 are separators; the rest map onto the six BCD digits.
  function automatic logic is_sep(input logic [2:0] idx);
    return (idx == 3'd2) || (idx == 3'd5);
  endfunction

  function automatic logic [3:0] snap_digit(input logic [23:0] snap, input logic [2:0] idx);
    logic [3:0] d;
    case (idx)
      3'd0:    d = snap[23:20];
      3'd1:    d = snap[19:16];
      3'd3:    d = snap[15:12];
      3'd4:    d = snap[11:8];
      3'd6:    d = snap[7:4];
      3'd7:    d = snap[3:0];
      default: d = 4'h0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/lcd_time_writer_if.sv
// Valid/ready item channel from the time writer to the LCD write stage.
interface lcd_time_writer_if;
  logic       out_valid;
  logic       out_ready;
  logic       out_rs;
  logic [7:0] out_data;

  modport master (output out_valid, output out_rs, output out_data, input out_ready);
  modport slave  (input out_valid, input out_rs, input out_data, output out_ready);
endinterface

// File: rtl/bcd_to_ascii.sv
// One BCD digit to its display code; out-of-range digits show '?'.
module bcd_to_ascii
  import lcd_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_blank,
  output logic [7:0] o_code
);

  always_comb begin
    o_code = ASCII_ZERO + {4'h0, i_digit};
    if (i_blank && (i_digit == 4'h0)) o_code = ASCII_SPACE;
    else if (i_digit > 4'd9)          o_code = ASCII_QMARK;
  end

endmodule

// File: rtl/lcd_time_writer.sv
// Streams Set-DDRAM + "HH:MM:SS" from a snapshot of the BCD time, one item per
// valid/ready transfer, chaining a merged pending refresh with no idle cycle.
module lcd_time_writer
  import lcd_pkg::*;
#(
  parameter logic [6:0] DDRAM_ADDR      = 7'h04,
  parameter logic [7:0] SEP_CHAR        = 8'h3A,
  parameter bit         BLANK_LEAD_ZERO = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      refresh,
  input  logic [23:0]               time_bcd,
  lcd_time_writer_if.master         lcd,
  output logic                      busy,
  output logic                      done
);

  logic [1:0]  r_state;
  logic [2:0]  r_idx;
  logic [23:0] r_snap;
  logic        r_pending;
  logic        r_valid;
  logic        r_rs;
  logic [7:0]  r_data;
  logic        r_busy;
  logic        r_done;

  logic        w_xfer;
  logic        w_last;
  logic        w_start;
  logic [2:0]  w_next_idx;
  logic [7:0]  w_code;
  logic [7:0]  w_char;
  logic [7:0]  w_addr_cmd;

  assign w_xfer     = r_valid && lcd.out_ready;
  assign w_last     = (r_state == ST_CHARS) && (r_idx == LAST_CHAR_IDX) && w_xfer;
  // A refresh landing on the final transfer edge chains just like a pending one.
  assign w_start    = (r_state == ST_IDLE) ? (refresh || r_pending)
                                           : (w_last && (r_pending || refresh));
  assign w_next_idx = (r_state == ST_ADDR) ? 3'd0 : r_idx + 3'd1;
  assign w_addr_cmd = LCD_CMD_SET_DDRAM | {1'b0, DDRAM_ADDR};

  // Single converter, fed with the digit for the item that follows the current one.
  bcd_to_ascii u_conv (
    .i_digit (snap_digit(r_snap, w_next_idx)),
    .i_blank (BLANK_LEAD_ZERO && (w_next_idx == 3'd0)),
    .o_code  (w_code)
  );

  assign w_char = is_sep(w_next_idx) ? SEP_CHAR : w_code;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_idx     <= 3'd0;
      r_snap    <= 24'h0;
      r_pending <= 1'b0;
      r_valid   <= 1'b0;
      r_rs      <= 1'b0;
      r_data    <= 8'h00;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_start) begin
        r_state   <= ST_ADDR;
        r_idx     <= 3'd0;
        r_snap    <= time_bcd;
        r_pending <= 1'b0;
        r_valid   <= 1'b1;
        r_rs      <= 1'b0;
        r_data    <= w_addr_cmd;
        r_busy    <= 1'b1;
        r_done    <= w_last;
      end else if (w_last) begin
        r_state   <= ST_IDLE;
        r_pending <= 1'b0;
        r_valid   <= 1'b0;
        r_busy    <= 1'b0;
        r_done    <= 1'b1;
      end else begin
        if (refresh && (r_state != ST_IDLE)) r_pending <= 1'b1;
        if (w_xfer) begin
          r_state <= ST_CHARS;
          r_idx   <= w_next_idx;
          r_rs    <= 1'b1;
          r_data  <= w_char;
        end
      end
    end
  end

  assign lcd.out_valid = r_valid;
  assign lcd.out_rs    = r_rs;
  assign lcd.out_data  = r_data;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule

// File: tb/tb_lcd_time_writer.sv
// Directed + randomized bench: two writers (default, and blanked hours at 0x40)
// checked against an item-list model of the HH:MM:SS display.
module tb_lcd_time_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        refresh;
  logic [23:0] tbcd;
  logic        ready;
  logic        busy0, done0, busy1, done1;

  lcd_time_writer_if if0 ();
  lcd_time_writer_if if1 ();
  assign if0.out_ready = ready;
  assign if1.out_ready = ready;

  lcd_time_writer dut0 (
    .clk (clk), .rst (rst), .refresh (refresh), .time_bcd (tbcd),
    .lcd (if0), .busy (busy0), .done (done0)
  );

  lcd_time_writer #(.DDRAM_ADDR (7'h40), .BLANK_LEAD_ZERO (1'b1)) dut1 (
    .clk (clk), .rst (rst), .refresh (refresh), .time_bcd (tbcd),
    .lcd (if1), .busy (busy1), .done (done1)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  int ndone0 = 0, ndone1 = 0, done_cyc0 = 0, vcyc0 = 0;
  int c0, nd;
  logic [8:0] got0[$], got1[$], exp0[$], exp1[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Display code of one digit as the LCD should show it.
  function automatic logic [7:0] dch(input logic [3:0] d, input bit bl);
    if (bl && d == 4'd0) return 8'h20;
    if (d > 4'd9) return 8'h3F;
    return 8'h30 + {4'h0, d};
  endfunction

  // Expected nine items for time t on both writers.
  task automatic add_exp(input logic [23:0] t);
    logic [3:0] dg [6];
    int d;
    for (int k = 0; k < 6; k++) dg[k] = t[23-4*k -: 4];
    exp0.push_back({1'b0, 8'h84});
    exp1.push_back({1'b0, 8'hC0});
    for (int k = 0; k < 8; k++) begin
      if (k == 2 || k == 5) begin
        exp0.push_back({1'b1, 8'h3A});
        exp1.push_back({1'b1, 8'h3A});
      end else begin
        d = k - k / 3;
        exp0.push_back({1'b1, dch(dg[d], 1'b0)});
        exp1.push_back({1'b1, dch(dg[d], d == 0)});
      end
    end
  endtask

  // One clock: log transfers before the edge, check stall stability after it.
  task automatic step();
    logic st0, st1;
    logic [8:0] h0, h1;
    if (!rst && if0.out_valid && ready) got0.push_back({if0.out_rs, if0.out_data});
    if (!rst && if1.out_valid && ready) got1.push_back({if1.out_rs, if1.out_data});
    st0 = !rst && if0.out_valid && !ready;
    st1 = !rst && if1.out_valid && !ready;
    h0  = {if0.out_rs, if0.out_data};
    h1  = {if1.out_rs, if1.out_data};
    if (if0.out_valid) vcyc0++;
    @(posedge clk);
    #1;
    cyc++;
    if (st0) chk("stall_hold0", {if0.out_valid, if0.out_rs, if0.out_data}, {1'b1, h0});
    if (st1) chk("stall_hold1", {if1.out_valid, if1.out_rs, if1.out_data}, {1'b1, h1});
    if (done0) begin ndone0++; done_cyc0 = cyc; end
    if (done1) ndone1++;
  endtask

  task automatic cmp_q(input string tag);
    chk({tag, "_count0"}, got0.size(), exp0.size());
    for (int i = 0; i < got0.size() && i < exp0.size(); i++) chk({tag, "_item0"}, got0[i], exp0[i]);
    chk({tag, "_count1"}, got1.size(), exp1.size());
    for (int i = 0; i < got1.size() && i < exp1.size(); i++) chk({tag, "_item1"}, got1[i], exp1[i]);
    got0.delete(); got1.delete(); exp0.delete(); exp1.delete();
  endtask

  // rmode: 0 ready high, 1 pattern 1,0,0,1, 2 random; scramble moves time every cycle.
  task automatic run_seq(input logic [23:0] t, input int rmode, input bit scramble);
    add_exp(t);
    tbcd = t; refresh = 1'b1; ready = 1'b1;
    step();
    refresh = 1'b0;
    for (int k = 0; k < 200 && (busy0 || busy1); k++) begin
      if (rmode == 0)      ready = 1'b1;
      else if (rmode == 1) ready = (k % 4 == 0) || (k % 4 == 3);
      else                 ready = 1'($urandom_range(0, 1));
      if (scramble) tbcd = 24'($urandom);
      step();
    end
    ready = 1'b1;
    chk("timeout_busy", {30'h0, busy0, busy1}, 32'h0);
  endtask

  initial begin
    rst = 1'b1; refresh = 1'b0; tbcd = 24'h0; ready = 1'b1;
    step(); step();
    chk("rst_valid0", if0.out_valid, 0);
    chk("rst_rs0",    if0.out_rs, 0);
    chk("rst_data0",  if0.out_data, 8'h00);
    chk("rst_busy0",  busy0, 0);
    chk("rst_done0",  done0, 0);
    chk("rst_valid1", if1.out_valid, 0);
    rst = 1'b0;
    step();

    // basic sequence with latency and timing
    ndone0 = 0; ndone1 = 0;
    add_exp(24'h123456);
    tbcd = 24'h123456; refresh = 1'b1;
    step();
    refresh = 1'b0; c0 = cyc; vcyc0 = 0;
    chk("lat_valid", if0.out_valid, 1);
    chk("lat_item",  {if0.out_rs, if0.out_data}, 9'h084);
    chk("lat_busy",  busy0, 1);
    chk("lat_item1", {if1.out_rs, if1.out_data}, 9'h0C0);
    for (int k = 0; k < 40 && (busy0 || busy1); k++) step();
    chk("basic_done_lat",  done_cyc0 - c0, 9);
    chk("basic_valid_cyc", vcyc0, 9);
    chk("basic_done_now",  done0, 1);
    chk("basic_valid_off", if0.out_valid, 0);
    step();
    chk("basic_done_pulse", done0, 0);
    chk("basic_ndone", ndone0, 1);
    cmp_q("basic");

    // backpressure 1,0,0,1
    run_seq(24'h235901, 1, 1'b0);
    cmp_q("backpressure");

    // refresh while busy: three extra pulses merge into one chained sequence
    ndone0 = 0; ndone1 = 0;
    add_exp(24'h123456); add_exp(24'h123457);
    tbcd = 24'h123456; refresh = 1'b1; ready = 1'b1;
    step();
    refresh = 1'b0; c0 = cyc; vcyc0 = 0;
    tbcd = 24'h123457;
    for (int k = 0; k < 60 && (busy0 || busy1); k++) begin
      refresh = (k == 1) || (k == 3) || (k == 5);
      step();
    end
    refresh = 1'b0;
    chk("chain_ndone0", ndone0, 2);
    chk("chain_ndone1", ndone1, 2);
    chk("chain_end_cyc", done_cyc0 - c0, 18);
    chk("chain_valid_cyc", vcyc0, 18);
    cmp_q("chain");
    step();

    // digit handling
    run_seq(24'hA00000, 0, 1'b0);
    chk("htens_A0", got0[1], 9'h13F);
    chk("htens_A1", got1[1], 9'h13F);
    cmp_q("digit_A");
    run_seq(24'h070509, 0, 1'b0);
    chk("blank_on",  got1[1], 9'h120);
    chk("blank_ho",  got1[2], 9'h137);
    chk("blank_off", got0[1], 9'h130);
    cmp_q("digit_blank");

    // reset mid-sequence
    ndone0 = 0;
    tbcd = 24'h112233; refresh = 1'b1; ready = 1'b1;
    step();
    refresh = 1'b0;
    step(); step(); step();
    chk("mid_xfers", got0.size(), 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_valid0", if0.out_valid, 0);
    chk("mid_busy0",  busy0, 0);
    chk("mid_done0",  done0, 0);
    chk("mid_data0",  if0.out_data, 8'h00);
    chk("mid_valid1", if1.out_valid, 0);
    nd = ndone0;
    step(); step(); step();
    chk("mid_no_done", ndone0, nd);
    chk("mid_idle_busy", busy0, 0);
    got0.delete(); got1.delete();
    run_seq(24'h112233, 0, 1'b0);
    cmp_q("mid_restart");

    // snapshot under random time churn and random ready
    for (int it = 0; it < 12; it++) begin
      run_seq(24'($urandom), 2, 1'b1);
      cmp_q("snapshot");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
